// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light sequencer and its mode decoder:
// phase encoding and default timing constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_MG = 2'b00,  // main green / side red
    ST_MY = 2'b01,  // main yellow / side red
    ST_SG = 2'b10,  // side green / main red
    ST_SY = 2'b11   // side yellow / main red
  } phase_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_SHORT_T  = 5;
  localparam int DEF_LONG_T   = 20;
  localparam int DEF_YELLOW_T = 3;

  // Yellow phases are the odd encodings.
  function automatic logic is_yellow(input logic [1:0] p);
    return p[0];
  endfunction

endpackage

// File: rtl/traffic_seq_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, saturating at the
// terminal count, and reloads the terminal count on every phase advance.
module phase_timer #(
  parameter int CNT_W  = 8,
  parameter int RST_TC = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W:0]   load_val,
  output logic             full
);

  localparam logic [CNT_W:0] LP_RST_TC = (CNT_W+1)'(RST_TC);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   r_tc;
  logic [CNT_W:0]   w_last;
  logic             w_full;

  // tc is one bit wider than cnt so a terminal count of 2^CNT_W is representable.
  assign w_last = r_tc - (CNT_W+1)'(1);
  assign w_full = ({1'b0, r_cnt} == w_last);
  assign full   = w_full;

  // Count while running, hold at terminal count, clear and reload on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_tc  <= LP_RST_TC;
    end else if (load) begin
      r_cnt <= '0;
      r_tc  <= load_val;
    end else if (run && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_seq.sv
// Traffic-light sequencer: phase register, car-request synchronizer and
// latch, lamp decode, and the phase timer feeding the external decoder.
module traffic_seq
  import traffic_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SHORT_T  = DEF_SHORT_T,
  parameter int LONG_T   = DEF_LONG_T,
  parameter int YELLOW_T = DEF_YELLOW_T
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car,
  input  logic       mode,
  input  logic       delay,
  output logic [1:0] state,
  output logic       full,
  output logic       c,
  output logic       main_g,
  output logic       main_y,
  output logic       main_r,
  output logic       side_g,
  output logic       side_y,
  output logic       side_r
);

  localparam int TC_MAX = 2 ** CNT_W;

  if (SHORT_T < 2 || SHORT_T > TC_MAX ||
      LONG_T < 2 || LONG_T > TC_MAX ||
      YELLOW_T < 2 || YELLOW_T > TC_MAX) begin : g_cfg_err
    $error("traffic_seq: terminal counts must lie in [2, 2**CNT_W]");
  end

  localparam logic [CNT_W:0] LP_SHORT  = (CNT_W+1)'(SHORT_T);
  localparam logic [CNT_W:0] LP_LONG   = (CNT_W+1)'(LONG_T);
  localparam logic [CNT_W:0] LP_YELLOW = (CNT_W+1)'(YELLOW_T);

  phase_t         r_state;
  phase_t         w_state_nxt;
  logic [1:0]     w_state_inc;
  logic [CNT_W:0] w_load_val;
  logic           w_enter_sg;
  logic           r_sync1;
  logic           r_sync2;
  logic           r_c;

  assign w_state_inc = r_state + 2'd1;
  assign w_load_val  = is_yellow(w_state_inc) ? LP_YELLOW : (delay ? LP_LONG : LP_SHORT);
  assign w_enter_sg  = !mode && (r_state == ST_MY);

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_TC (SHORT_T)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (mode),
    .load     (!mode),
    .load_val (w_load_val),
    .full     (full)
  );

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_MG;
    else     r_state <= w_state_nxt;
  end

  // Next phase follows the decoder's mode unconditionally; lamps decode the phase.
  always_comb begin
    w_state_nxt = r_state;
    main_g = 1'b0;
    main_y = 1'b0;
    main_r = 1'b0;
    side_g = 1'b0;
    side_y = 1'b0;
    side_r = 1'b0;
    if (!mode) w_state_nxt = phase_t'(w_state_inc);
    case (r_state)
      ST_MG: begin main_g = 1'b1; side_r = 1'b1; end
      ST_MY: begin main_y = 1'b1; side_r = 1'b1; end
      ST_SG: begin main_r = 1'b1; side_g = 1'b1; end
      ST_SY: begin main_r = 1'b1; side_y = 1'b1; end
      default: ;
    endcase
  end

  // Two-flop synchronizer for the asynchronous car sensor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= car;
      r_sync2 <= r_sync1;
    end
  end

  // Request latch: served on entry to side green, which outranks a new request.
  always_ff @(posedge clk) begin
    if (rst)             r_c <= 1'b0;
    else if (w_enter_sg) r_c <= 1'b0;
    else if (r_sync2)    r_c <= 1'b1;
  end

  assign state = r_state;
  assign c     = r_c;

endmodule

// File: tb/tb_traffic_seq.sv
// Self-checking bench for traffic_seq with a behavioural reference model.
module tb_traffic_seq;

  localparam int SHORT = 5;
  localparam int LONG  = 20;
  localparam int YEL   = 3;

  logic       clk = 1'b0;
  logic       rst, car, mode, delay;
  logic [1:0] state;
  logic       full, c;
  logic       main_g, main_y, main_r, side_g, side_y, side_r;

  int total = 0;
  int bad   = 0;

  // reference model: phase number, cycles spent in phase, phase length,
  // pending request, car samples taken at the previous two edges
  int m_ph, m_age, m_len;
  bit m_req, q0, q1;
  bit loop_en;

  always #5 clk = ~clk;

  traffic_seq #(
    .CNT_W    (8),
    .SHORT_T  (SHORT),
    .LONG_T   (LONG),
    .YELLOW_T (YEL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .car    (car),
    .mode   (mode),
    .delay  (delay),
    .state  (state),
    .full   (full),
    .c      (c),
    .main_g (main_g),
    .main_y (main_y),
    .main_r (main_r),
    .side_g (side_g),
    .side_y (side_y),
    .side_r (side_r)
  );

  function automatic int exp_full();
    return (m_age >= m_len - 1) ? 1 : 0;
  endfunction

  function automatic int exp_cnt();
    return (m_age < m_len - 1) ? m_age : m_len - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=condition", tag);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_ph = 0; m_age = 0; m_len = SHORT; m_req = 0; q0 = 0; q1 = 0;
    end else begin
      if (!mode && m_ph == 1) m_req = 0;
      else if (q1)            m_req = 1;
      if (!mode) begin
        m_ph  = (m_ph + 1) % 4;
        m_age = 0;
        m_len = (m_ph % 2 == 1) ? YEL : (delay ? LONG : SHORT);
      end else begin
        m_age++;
      end
      q1 = q0;
      q0 = car;
    end
  endtask

  task automatic check_all();
    logic [2:0] em, es;
    em = (m_ph == 0) ? 3'b100 : (m_ph == 1) ? 3'b010 : 3'b001;
    es = (m_ph == 2) ? 3'b100 : (m_ph == 3) ? 3'b010 : 3'b001;
    chk("state", state, m_ph);
    chk("full", full, exp_full());
    chk("c", c, m_req);
    chk("main_lamps", {main_g, main_y, main_r}, em);
    chk("side_lamps", {side_g, side_y, side_r}, es);
    chk("cnt", dut.u_timer.r_cnt, exp_cnt());
    chk("tc", dut.u_timer.r_tc, m_len);
  endtask

  task automatic tick();
    if (loop_en) mode = (exp_full() != 0) ? 1'b0 : 1'b1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int guard;
    rst = 1'b1; mode = 1'b1; delay = 1'b0; car = 1'b0; loop_en = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    tick();
    rst = 1'b0;

    // free-running count in main green: full rises after 4 cycles and holds
    repeat (4) tick();
    chk("full_rise", full, 1);
    repeat (4) tick();
    chk("full_hold", full, 1);

    // closed loop, short greens, then random delay at each advance
    loop_en = 1'b1;
    repeat (40) tick();
    for (int i = 0; i < 80; i++) begin
      delay = 1'($urandom_range(0, 1));
      tick();
    end
    delay = 1'b0;

    // one-cycle car pulse in main green
    guard = 0;
    while (!(m_ph == 0 && m_age == 0) && guard < 60) begin tick(); guard++; end
    if (guard >= 60) timeout("wait_mg_pulse");
    car = 1'b1;
    tick();
    car = 1'b0;
    tick();
    chk("car_lat2", c, 0);
    tick();
    chk("car_lat3", c, 1);
    guard = 0;
    while (m_ph != 2 && guard < 60) begin tick(); guard++; end
    if (guard >= 60) timeout("wait_sg_serve");
    chk("served_c", c, 0);

    // car held across the entry into side green
    guard = 0;
    while (!(m_ph == 1 && m_age == 0) && guard < 60) begin tick(); guard++; end
    if (guard >= 60) timeout("wait_my");
    car = 1'b1;
    guard = 0;
    while (m_ph != 2 && guard < 10) begin tick(); guard++; end
    if (guard >= 10) timeout("wait_sg_clash");
    chk("clash_state", state, 2);
    chk("clash_c", c, 0);
    tick();
    chk("reset_c", c, 1);
    car = 1'b0;
    repeat (6) tick();

    // forced advance at cnt=2 in main green
    guard = 0;
    while (!(m_ph == 0 && m_age == 2) && guard < 60) begin tick(); guard++; end
    if (guard >= 60) timeout("wait_mg_cnt2");
    chk("force_full_pre", full, 0);
    loop_en = 1'b0;
    mode = 1'b0;
    tick();
    chk("force_state", state, 1);
    chk("force_cnt", dut.u_timer.r_cnt, 0);
    chk("force_tc", dut.u_timer.r_tc, 3);
    loop_en = 1'b1;

    // reset mid side green with a pending request
    car = 1'b1;
    guard = 0;
    while (!(m_ph == 2 && m_req && m_age >= 1) && guard < 80) begin tick(); guard++; end
    if (guard >= 80) timeout("wait_sg_req");
    chk("pre_rst_c", c, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    car = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_cnt", dut.u_timer.r_cnt, 0);
    chk("rst_c", c, 0);
    chk("rst_main_g", main_g, 1);

    // random soak: mostly closed loop, occasional forced mode and resets
    for (int i = 0; i < 400; i++) begin
      car     = 1'($urandom_range(0, 1));
      delay   = 1'($urandom_range(0, 1));
      loop_en = ($urandom_range(0, 9) != 0);
      if (!loop_en) mode = 1'($urandom_range(0, 1));
      rst     = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
    loop_en = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_seq.md
# traffic_seq

Sequential counterpart of the traffic-light mode decoder: owns the phase register, the phase timer and the side-street car request, and drives `state`, `full` and `c` into the decoder. It consumes the decoder's `mode`/`delay` outputs to decide when to advance and how long the next green lasts. It also decodes the six lamp outputs for the intersection.

## Interface
- `CNT_W`, 8, phase-timer width.
- `SHORT_T`, 5, green length in cycles when `delay`=0 at entry.
- `LONG_T`, 20, green length in cycles when `delay`=1 at entry.
- `YELLOW_T`, 3, yellow length in cycles, fixed.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `car` in 1: raw side-street sensor, asynchronous to `clk`.
- `mode` in 1: from decoder; 1 = hold and count, 0 = advance phase.
- `delay` in 1: from decoder; selects `LONG_T` for the phase being entered.
- `state` out 2: current phase.
- `full` out 1: timer at terminal count of the current phase.
- `c` out 1: latched, synchronized car request.
- `main_g`, `main_y`, `main_r`, `side_g`, `side_y`, `side_r` out 1 each: lamp drives.

## Operation
- Phase encoding:
  - 00 main green / side red.
  - 01 main yellow / side red.
  - 10 side green / main red.
  - 11 side yellow / main red.
  - Advance is always `state+1` mod 4 (11→00).
- Phase timer:
  - `cnt` counts up from 0 while `mode`=1.
  - It saturates at `tc-1`.
  - `full` = (`cnt` == `tc-1`), decoded combinationally from registers.
- On `mode`=0, at the next edge:
  - `state` advances and `cnt` is cleared to 0.
  - `tc` is loaded for the new phase: `YELLOW_T` if the new state is odd, otherwise `LONG_T` if `delay`=1, else `SHORT_T`.
  - Advance happens even if `full`=0; the sequencer obeys `mode` unconditionally.
- Car request:
  - `car` passes through a 2-flop synchronizer.
  - A synchronized high sets `c`.
  - `c` is cleared on the edge where `state` transitions into 10.
  - Simultaneous set and clear: clear wins.
  - `c` stays set through phases 00/01 until side green is served.
- Lamps are a pure decode of `state`. Exactly one of each street's three lamps is high at all times; for phases 10/11 the main street shows red.

## Timing
- Reset values:
  - `state`=00, `cnt`=0, `tc`=`SHORT_T`.
  - `c`=0, synchronizer flops 0, `full`=0 (requires `SHORT_T`>1).
  - `main_g`=1, `side_r`=1; all other lamps 0.
- Phase duration: a phase loaded with `tc`=N shows `full`=0 for N-1 cycles, then `full`=1. With the decoder in loop, the advance occurs on the edge after the first `full`=1 cycle, so each phase lasts exactly N cycles.
- Car latency: `car` rising to `c`=1 takes 3 edges (2 synchronizer flops plus the latch).
- `rst` asserted mid-phase takes effect at the next edge, regardless of `mode`, `delay` or `car`.
- Width rule: all terminal counts must be ≥2 and ≤2^`CNT_W`. Parameters violating this are a configuration error, checked by an elaboration-time assertion.
- The combinational loop `full`/`c`/`state` → decoder → `mode`/`delay` → registers is legal: `mode`/`delay` are only sampled at the edge.

## Structure
- Shared package `traffic_pkg`:
  - State constants `ST_MG`=2'b00, `ST_MY`=2'b01, `ST_SG`=2'b10, `ST_SY`=2'b11.
  - Default timing constants shared with the decoder and the top level.
- One sub-module: `phase_timer`.
  - Holds `cnt` and `tc`, produces `full`.
  - Inputs: `clk`, `rst`, `run`(=`mode`), `load`(=~`mode`), `load_val`.
- Synchronizer, request latch, state register and lamp decode stay in `traffic_seq`.

## Test plan
- Reset, then hold `mode`=1 with no car:
  - `state`=00, `main_g`=1, `side_r`=1.
  - `full` rises after exactly 4 cycles (`SHORT_T`=5) and stays high.
- Closed loop with the decoder, `car`=0:
  - The sequence 00→01→10→11→00 repeats with phase lengths 5,3,5,3 when `delay`=0, and 20 for a green entered with `delay`=1.
  - Exactly one lamp per street is high every cycle.
- Pulse `car` high for 1 cycle during phase 00:
  - `c`=1 on the 3rd edge.
  - `c` holds through 01.
  - `c` clears on the edge entering 10.
- `car` held high on the exact cycle `state` enters 10: clear wins, and `c` re-sets only from later synchronized samples.
- Force `mode`=0 while `full`=0 at `cnt`=2 in phase 00: next edge gives `state`=01, `cnt`=0, `tc`=3.
- Assert `rst` for 1 cycle mid-phase 10 with `c`=1: next edge gives `state`=00, `cnt`=0, `c`=0, `main_g`=1.
